// File: rtl/gray_counter_nbits_if.sv
// Control and data bundle for the up/down Gray counter.
// The master drives the operation controls; the slave returns the registered count.
interface gray_counter_nbits_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             up;
    logic             load;
    logic             gray_n;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Dout;
    logic [WIDTH-1:0] Bout;
    logic             valid;
    logic             wrap;

    modport master (
        output EN, up, load, gray_n, Din,
        input  Dout, Bout, valid, wrap
    );

    modport slave (
        input  EN, up, load, gray_n, Din,
        output Dout, Bout, valid, wrap
    );
endinterface

// File: rtl/gray_counter_nbits.sv
// Loadable up/down counter with registered binary and Gray outputs.
// The Gray output has its own flops, so no input reaches an output combinationally.
module gray_counter_nbits #(
    parameter int WIDTH = 4,
    parameter int INIT  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_counter_nbits_if.slave  bus
);
    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] gray;
    logic             valid_q;
    logic             wrap_q;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic             nxt_wrap;

    // Load value: Gray input decoded by a running XOR from the MSB down
    always_comb begin
        load_val = bus.Din;
        if (bus.gray_n) begin
            load_val[WIDTH-1] = bus.Din[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                load_val[i] = load_val[i+1] ^ bus.Din[i];
            end
        end
    end

    // Next binary count and wrap flag for this edge
    always_comb begin
        nxt      = cnt;
        nxt_wrap = 1'b0;
        if (bus.load) begin
            nxt = load_val;
        end else if (bus.up) begin
            nxt      = cnt + 1'b1;
            nxt_wrap = &cnt;
        end else begin
            nxt      = cnt - 1'b1;
            nxt_wrap = ~|cnt;
        end
    end

    // Count state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= INIT_B;
            gray    <= INIT_G;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.EN) begin
            cnt     <= nxt;
            gray    <= nxt ^ (nxt >> 1);
            valid_q <= 1'b1;
            wrap_q  <= nxt_wrap;
        end else begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end
    end

    assign bus.Bout  = cnt;
    assign bus.Dout  = gray;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: doc/gray_counter_nbits.md
GRAY_COUNTER_NBITS -- requirements
Module: gray_counter_nbits

Interface
REQ-001 Parameter WIDTH, default 4, counter/code width in bits; legal range 2..16.
REQ-002 Parameter INIT, default 0, binary reset value of the count; legal range 0..2^WIDTH-1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 EN  input  1  operation enable; 0 = hold all state.
REQ-006 up  input  1  count direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  load Din into the counter instead of counting.
REQ-008 gray_n  input  1  format of Din on load; 0 = binary, 1 = Gray.
REQ-009 Din  input  WIDTH  load value.
REQ-010 Dout  output  WIDTH  current count in reflected-binary Gray code, registered.
REQ-011 Bout  output  WIDTH  current count in binary, registered.
REQ-012 valid  output  1  registered; 1 when the previous edge performed an operation.
REQ-013 wrap  output  1  registered one-cycle pulse on count wrap-around.

Function
REQ-014 Internal state is a WIDTH-bit binary count C; Bout = C and Dout = C ^ (C >> 1) at all times, both driven from flops.
REQ-015 All state updates on the rising clk edge; a change sampled at edge N is visible on outputs after edge N (latency 1 cycle).
REQ-016 Operation priority per edge: EN=0 -> hold; EN=1 and load=1 -> load; EN=1 and load=0 -> count.
REQ-017 EN=0: C, Dout, Bout hold; valid and wrap go to 0 on that edge.
REQ-018 Load with gray_n=0: C <= Din.
REQ-019 Load with gray_n=1: C <= Gray-to-binary(Din), bit i = XOR of Din[WIDTH-1:i].
REQ-020 Load ignores up; load sets wrap to 0 and valid to 1.
REQ-021 Count with up=1: C <= C + 1 modulo 2^WIDTH; up=0: C <= C - 1 modulo 2^WIDTH.
REQ-022 wrap = 1 for exactly the cycle after an edge where up=1 and C = 2^WIDTH-1, or up=0 and C = 0; otherwise 0.
REQ-023 Successive Dout values produced by counting (not load) differ in exactly one bit, including across wrap.
REQ-024 Direction may change on any cycle with no dead cycle; the next edge uses the new direction.
REQ-025 Din, up, gray_n are don't-care when EN=0; Din and gray_n are don't-care when load=0.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 rst_n=0 immediately, independent of clk: C = INIT, Bout = INIT, Dout = INIT ^ (INIT >> 1), valid = 0, wrap = 0.
REQ-028 Reset asserted mid-count aborts the operation; no partial update survives.
REQ-029 First edge with rst_n=1 performs a normal operation per REQ-016.

Verification (WIDTH=4, INIT=0 unless stated)
REQ-030 Reset, EN=1 up=1 load=0 for 16 edges -> Dout steps 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only after the 16th edge; valid=1 throughout.
REQ-031 From reset, EN=1 up=0 one edge -> Bout=1111, Dout=1000, wrap=1; next edge -> Bout=1110, Dout=1001, wrap=0.
REQ-032 load=1 gray_n=1 Din=1011 -> Bout=1101, Dout=1011; load=1 gray_n=0 Din=0110 -> Bout=0110, Dout=0101; wrap=0 both.
REQ-033 Count to Bout=0101, EN=0 for 3 edges with Din/up/load toggling -> Bout=0101, Dout=0111 held, valid=0, wrap=0.
REQ-034 Assert rst_n=0 between edges while Bout=1010 -> outputs reset without a clk edge; with INIT=5 Bout=0101, Dout=0111.
REQ-035 Random up/EN/load run with WIDTH=8 -> scoreboard matches Bout/Dout/wrap every cycle; Hamming distance 1 on every counting step.
